// File: rtl/scariv_brtag_alloc.sv
// Branch-tag allocator and resolver.
// Hands out branch tags to the branch slots of each dispatch group, tracks
// which live tags are younger than each tag, frees a tag on correct
// resolution, and on a mispredict or flush squashes the affected tags and
// broadcasts a one-cycle kill mask to the schedulers.
//
// Dispatch handshake: a group transfers on a cycle where i_disp_valid and
// o_disp_ready are both high. o_disp_ready does not depend on i_disp_valid.
// o_disp_brtag and o_disp_brmask are only meaningful on a transfer cycle.
// A group that does not transfer changes no state.
module scariv_brtag_alloc #(
  parameter int BRTAG_SIZE = 8,
  parameter int DISP_SIZE  = 4,
  parameter int TAG_W      = $clog2(BRTAG_SIZE)
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_disp_valid,
  input  logic [DISP_SIZE-1:0]            i_disp_is_br,
  output logic                            o_disp_ready,
  output logic [DISP_SIZE*TAG_W-1:0]      o_disp_brtag,
  output logic [DISP_SIZE*BRTAG_SIZE-1:0] o_disp_brmask,
  input  logic                            i_br_upd_valid,
  input  logic [TAG_W-1:0]                i_br_upd_tag,
  input  logic                            i_br_upd_mispred,
  input  logic                            i_flush,
  output logic                            o_kill_valid,
  output logic [BRTAG_SIZE-1:0]           o_kill_mask,
  output logic [TAG_W:0]                  o_free_count
);

  localparam int NBR_W = $clog2(DISP_SIZE + 1);
  localparam int CNT_W = (NBR_W > TAG_W + 1) ? NBR_W : TAG_W + 1;

  // Architectural state
  logic [BRTAG_SIZE-1:0] live_q, live_d;
  logic [BRTAG_SIZE-1:0] younger_q [BRTAG_SIZE];
  logic [BRTAG_SIZE-1:0] younger_d [BRTAG_SIZE];
  logic                  kill_valid_q, kill_valid_d;
  logic [BRTAG_SIZE-1:0] kill_mask_q, kill_mask_d;

  // Combinational helpers
  logic [TAG_W:0]        live_cnt;
  logic [TAG_W:0]        free_cnt;
  logic [CNT_W-1:0]      nbr;
  logic [BRTAG_SIZE-1:0] upd_oh;
  logic [BRTAG_SIZE-1:0] correct_clear;
  logic                  upd_live;
  logic                  accept;
  logic [BRTAG_SIZE-1:0] avail;
  logic                  found;
  logic [TAG_W-1:0]      slot_tag [DISP_SIZE];
  logic [BRTAG_SIZE-1:0] slot_oh  [DISP_SIZE];
  logic [BRTAG_SIZE-1:0] slot_mask [DISP_SIZE];
  logic [BRTAG_SIZE-1:0] grp_prev;
  logic [BRTAG_SIZE-1:0] grp_all;
  logic [BRTAG_SIZE-1:0] later;
  logic [BRTAG_SIZE-1:0] kill_vec;

  // Free count from registered live bits, branch count of the offered group,
  // and the readiness decision.
  always_comb begin
    live_cnt = '0;
    for (int b = 0; b < BRTAG_SIZE; b++) begin
      live_cnt = live_cnt + (TAG_W+1)'(live_q[b]);
    end
    free_cnt = (TAG_W+1)'(BRTAG_SIZE) - live_cnt;

    nbr = '0;
    for (int s = 0; s < DISP_SIZE; s++) begin
      nbr = nbr + CNT_W'(i_disp_is_br[s]);
    end

    upd_oh        = BRTAG_SIZE'(1) << i_br_upd_tag;
    correct_clear = (i_br_upd_valid && !i_br_upd_mispred) ? upd_oh : '0;
    upd_live      = i_br_upd_valid && live_q[i_br_upd_tag];

    o_disp_ready = !i_flush && !(i_br_upd_valid && i_br_upd_mispred) &&
                   (nbr <= CNT_W'(free_cnt));
    accept       = i_disp_valid && o_disp_ready;
  end

  // Tag pick: the k-th branch slot takes the k-th lowest index free in the
  // registered live bits, so a tag freed this cycle is not handed out until
  // the next one. Each slot's mask covers older live tags plus branches in
  // earlier slots of the same group.
  always_comb begin
    avail    = ~live_q;
    grp_prev = '0;
    found    = 1'b0;
    for (int s = 0; s < DISP_SIZE; s++) begin
      slot_tag[s]  = '0;
      slot_oh[s]   = '0;
      slot_mask[s] = (live_q & ~correct_clear) | grp_prev;
      if (i_disp_is_br[s]) begin
        found = 1'b0;
        for (int b = 0; b < BRTAG_SIZE; b++) begin
          if (!found && avail[b]) begin
            found       = 1'b1;
            slot_tag[s] = TAG_W'(b);
            slot_oh[s]  = BRTAG_SIZE'(1) << b;
          end
        end
        avail    = avail & ~slot_oh[s];
        grp_prev = grp_prev | slot_oh[s];
      end
    end
    grp_all = grp_prev;

    for (int s = 0; s < DISP_SIZE; s++) begin
      o_disp_brtag[s*TAG_W +: TAG_W]           = slot_tag[s];
      o_disp_brmask[s*BRTAG_SIZE +: BRTAG_SIZE] = slot_mask[s];
    end
  end

  // Next-state: flush beats resolution; allocation only on an accepted group
  // (which cannot coincide with a flush or mispredict).
  always_comb begin
    live_d       = live_q;
    younger_d    = younger_q;
    kill_valid_d = 1'b0;
    kill_mask_d  = '0;
    kill_vec     = '0;
    later        = '0;

    if (i_flush) begin
      live_d       = '0;
      kill_valid_d = 1'b1;
      kill_mask_d  = live_q;
    end else begin
      if (upd_live && i_br_upd_mispred) begin
        kill_vec     = (upd_oh | younger_q[i_br_upd_tag]) & live_q;
        live_d       = live_d & ~kill_vec;
        kill_valid_d = 1'b1;
        kill_mask_d  = kill_vec;
      end else if (upd_live) begin
        live_d = live_d & ~upd_oh;
      end

      if (accept) begin
        // Every currently live tag is older than the whole new group.
        for (int l = 0; l < BRTAG_SIZE; l++) begin
          if (live_q[l]) begin
            younger_d[l] = younger_q[l] | grp_all;
          end
        end
        // A new tag is older than the branches in later slots of its group.
        for (int s = DISP_SIZE - 1; s >= 0; s--) begin
          if (i_disp_is_br[s]) begin
            younger_d[slot_tag[s]] = later;
            later                  = later | slot_oh[s];
          end
        end
        live_d = live_d | grp_all;
      end
    end
  end

  // State registers; reset drops any pending kill pulse immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      live_q       <= '0;
      kill_valid_q <= 1'b0;
      kill_mask_q  <= '0;
      for (int t = 0; t < BRTAG_SIZE; t++) begin
        younger_q[t] <= '0;
      end
    end else begin
      live_q       <= live_d;
      kill_valid_q <= kill_valid_d;
      kill_mask_q  <= kill_mask_d;
      for (int t = 0; t < BRTAG_SIZE; t++) begin
        younger_q[t] <= younger_d[t];
      end
    end
  end

  assign o_kill_valid = kill_valid_q;
  assign o_kill_mask  = kill_mask_q;
  assign o_free_count = free_cnt;

endmodule

// File: tb/tb_scariv_brtag_alloc.sv
// Bench for scariv_brtag_alloc: directed scenarios followed by random
// traffic. The reference model keeps live tags as an age-ordered list.
module tb_scariv_brtag_alloc;

  localparam int BRTAG_SIZE = 8;
  localparam int DISP_SIZE  = 4;
  localparam int TAG_W      = 3;

  // ---------------- clock / reset / DUT ----------------
  logic                            clk = 1'b0;
  logic                            rst;
  logic                            disp_valid;
  logic [DISP_SIZE-1:0]            disp_is_br;
  logic                            disp_ready;
  logic [DISP_SIZE*TAG_W-1:0]      disp_brtag;
  logic [DISP_SIZE*BRTAG_SIZE-1:0] disp_brmask;
  logic                            upd_valid;
  logic [TAG_W-1:0]                upd_tag;
  logic                            upd_mispred;
  logic                            flush;
  logic                            kill_valid;
  logic [BRTAG_SIZE-1:0]           kill_mask;
  logic [TAG_W:0]                  free_count;

  always #5 clk = ~clk;

  scariv_brtag_alloc #(
    .BRTAG_SIZE(BRTAG_SIZE),
    .DISP_SIZE (DISP_SIZE),
    .TAG_W     (TAG_W)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_disp_valid    (disp_valid),
    .i_disp_is_br    (disp_is_br),
    .o_disp_ready    (disp_ready),
    .o_disp_brtag    (disp_brtag),
    .o_disp_brmask   (disp_brmask),
    .i_br_upd_valid  (upd_valid),
    .i_br_upd_tag    (upd_tag),
    .i_br_upd_mispred(upd_mispred),
    .i_flush         (flush),
    .o_kill_valid    (kill_valid),
    .o_kill_mask     (kill_mask),
    .o_free_count    (free_count)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic                            ready;
    logic                            accept;
    logic [DISP_SIZE*TAG_W-1:0]      tags;
    logic [DISP_SIZE*BRTAG_SIZE-1:0] masks;
    logic                            kill_valid;
    logic [BRTAG_SIZE-1:0]           kill_mask;
    logic [TAG_W:0]                  free;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int                    age_q[$];   // live tags, oldest first
  logic                  m_kill_v    = 1'b0;
  logic [BRTAG_SIZE-1:0] m_kill_mask = '0;

  task automatic model_step(input logic v, input logic [DISP_SIZE-1:0] br,
                            input logic uv, input logic [TAG_W-1:0] ut,
                            input logic um, input logic fl, input logic r,
                            output rec_t rec);
    logic [BRTAG_SIZE-1:0] live;
    logic [BRTAG_SIZE-1:0] cc;
    logic [BRTAG_SIZE-1:0] grp;
    logic [BRTAG_SIZE-1:0] kill;
    int free_list[$];
    int new_tags[$];
    int nbr;
    int free_n;
    int k;
    int idx;

    if (r) begin
      age_q.delete();
      m_kill_v    = 1'b0;
      m_kill_mask = '0;
    end
    live = '0;
    foreach (age_q[i]) live[age_q[i]] = 1'b1;

    rec            = '0;
    rec.kill_valid = m_kill_v;
    rec.kill_mask  = m_kill_mask;
    free_n         = BRTAG_SIZE - age_q.size();
    rec.free       = (TAG_W+1)'(free_n);

    nbr = 0;
    for (int i = 0; i < DISP_SIZE; i++) if (br[i]) nbr++;
    rec.ready  = !fl && !(uv && um) && (nbr <= free_n);
    rec.accept = v && rec.ready;

    for (int t = 0; t < BRTAG_SIZE; t++) if (!live[t]) free_list.push_back(t);
    cc  = (uv && !um) ? (BRTAG_SIZE'(1) << ut) : '0;
    grp = '0;
    k   = 0;
    for (int s = 0; s < DISP_SIZE; s++) begin
      rec.masks[s*BRTAG_SIZE +: BRTAG_SIZE] = (live & ~cc) | grp;
      if (br[s] && k < free_list.size()) begin
        rec.tags[s*TAG_W +: TAG_W] = TAG_W'(free_list[k]);
        grp[free_list[k]] = 1'b1;
        new_tags.push_back(free_list[k]);
        k++;
      end
    end

    m_kill_v    = 1'b0;
    m_kill_mask = '0;
    if (!r) begin
      if (fl) begin
        m_kill_v    = 1'b1;
        m_kill_mask = live;
        age_q.delete();
      end else begin
        idx = -1;
        foreach (age_q[i]) if (age_q[i] == int'(ut)) idx = i;
        if (uv && idx >= 0) begin
          if (um) begin
            kill = '0;
            while (age_q.size() > idx) begin
              kill[age_q[age_q.size()-1]] = 1'b1;
              void'(age_q.pop_back());
            end
            m_kill_v    = 1'b1;
            m_kill_mask = kill;
          end else begin
            age_q.delete(idx);
          end
        end
        if (rec.accept) foreach (new_tags[i]) age_q.push_back(new_tags[i]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [DISP_SIZE-1:0] br,
                       input logic uv, input logic [TAG_W-1:0] ut,
                       input logic um, input logic fl, input logic r);
    rec_t rec;
    rst         = r;
    disp_valid  = v;
    disp_is_br  = br;
    upd_valid   = uv;
    upd_tag     = ut;
    upd_mispred = um;
    flush       = fl;
    model_step(v, br, uv, ut, um, fl, r, rec);
    exp_q.push_back(rec);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("disp_ready", 64'(disp_ready), 64'(mon_e.ready));
      if (mon_e.accept) begin
        check("disp_brtag", 64'(disp_brtag), 64'(mon_e.tags));
        check("disp_brmask", 64'(disp_brmask), 64'(mon_e.masks));
      end
      check("kill_valid", 64'(kill_valid), 64'(mon_e.kill_valid));
      if (mon_e.kill_valid) check("kill_mask", 64'(kill_mask), 64'(mon_e.kill_mask));
      check("free_count", 64'(free_count), 64'(mon_e.free));
    end
  end

  // ---------------- stimulus ----------------
  logic [TAG_W-1:0] r_tag;

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_is_br = '0;
    upd_valid = 1'b0; upd_tag = '0; upd_mispred = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Allocate four branches, then reuse a correctly resolved tag.
    do_reset(); do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Mispredict squashes the tag and everything younger.
    do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    idle(); idle();

    // Not enough free tags: rejected twice, then accepted with 0,6,7.
    do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    // Full: a branch group is held, a branch-free group still goes.
    drive(1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Flush with all tags live beats a same-cycle mispredict.
    do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(); idle();

    // Back-to-back mispredicts.
    do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    idle();

    // Reset the cycle after a mispredict drops the pending pulse.
    do_reset();
    drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle();

    // Random traffic.
    repeat (600) begin
      if (age_q.size() > 0 && $urandom_range(0, 3) != 0)
        r_tag = TAG_W'(age_q[$urandom_range(0, age_q.size() - 1)]);
      else
        r_tag = TAG_W'($urandom_range(0, BRTAG_SIZE - 1));
      drive($urandom_range(0, 3) != 0,
            DISP_SIZE'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1,
            r_tag,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 149) == 0);
    end
    idle(); idle();

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scariv_brtag_alloc.md
Name: scariv_brtag_alloc

Overview:
Branch-tag allocator and resolver. It is the responder end of the branch-tag interface driven by the BRU issue unit, and the consumer of the BRU's EX3 branch-update result.
- Hands out tags to branch instructions in each dispatch group.
- Tracks live tags and which tags are younger than each tag.
- Frees tags on correct resolution.
- On mispredict, frees the mispredicted tag plus every younger tag and broadcasts a one-cycle kill mask to the schedulers.

Parameters:
BRTAG_SIZE, 8, number of branch tags; power of two, at least 2.
DISP_SIZE, 4, slots per dispatch group.
TAG_W, $clog2(BRTAG_SIZE), tag index width.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_disp_valid  in  1  dispatch group present.
i_disp_is_br  in  DISP_SIZE  per-slot branch flag.
o_disp_ready  out  1  group can be accepted this cycle.
o_disp_brtag  out  DISP_SIZE*TAG_W  tag assigned to each branch slot; 0 for non-branch slots.
o_disp_brmask  out  DISP_SIZE*BRTAG_SIZE  per-slot mask of older live tags the instruction depends on.
i_br_upd_valid  in  1  branch resolved (EX3).
i_br_upd_tag  in  TAG_W  resolved tag.
i_br_upd_mispred  in  1  resolution was a mispredict.
i_flush  in  1  full pipeline flush.
o_kill_valid  out  1  kill broadcast, one-cycle pulse.
o_kill_mask  out  BRTAG_SIZE  tags to squash.
o_free_count  out  TAG_W+1  number of free tags.

Behaviour:
State:
- live_q[BRTAG_SIZE].
- younger_q[BRTAG_SIZE][BRTAG_SIZE].
- kill registers.

Reset:
- live_q=0, younger_q=0.
- o_kill_valid=0, o_kill_mask=0.
- o_free_count=BRTAG_SIZE.

Dispatch readiness and acceptance:
- nbr = popcount(i_disp_is_br).
- o_disp_ready = ~i_flush & ~(i_br_upd_valid & i_br_upd_mispred) & (nbr <= free count of live_q).
- A group is accepted only when i_disp_valid & o_disp_ready. A non-accepted group changes no state.
- Non-branch groups (nbr=0) are always ready unless there is a flush or mispredict in that cycle.

Tag assignment (combinational from registered live_q):
- The k-th branch slot in slot order gets the k-th lowest free index.
- Tags freed in the current cycle are not reusable until the next cycle.

Brmask per slot i:
- (live_q & ~correct_clear) | tags of branch slots j<i in the same group.
- correct_clear = onehot(i_br_upd_tag) when i_br_upd_valid & ~i_br_upd_mispred; otherwise 0.
- A branch's own tag is not in its own mask.

On accept, for each allocated tag t:
- live_q[t] <= 1.
- younger_q[t] <= 0, then OR in the tags allocated to later slots of the same group.
- For every live l: younger_q[l] |= t.

Correct resolution (valid, ~mispred, live_q[tag]=1):
- live_q[tag] <= 0.
- No kill pulse.

Mispredict resolution (valid, mispred, live_q[tag]=1):
- kill = (onehot(tag) | younger_q[tag]) & live_q.
- live_q &= ~kill.
- Next cycle: o_kill_valid=1, o_kill_mask=kill.

Resolution of a non-live tag: ignored, no state change, no kill.

Flush:
- live_q <= 0.
- Next cycle: o_kill_valid=1, o_kill_mask = live_q of the flush cycle (may be 0).
- Flush takes priority over a same-cycle br_upd.

Kill pulse:
- o_kill_valid deasserts the cycle after a pulse unless a new kill occurs.
- Back-to-back mispredicts produce back-to-back pulses.

Free count: o_free_count = BRTAG_SIZE - popcount(live_q), registered-state based.

Full condition: free count 0 and nbr>0 gives o_disp_ready=0. A branch-free group still dispatches.

Wrap-around: none. Allocation is by free-bitmap priority, and age is carried only in younger_q.

Reset mid-operation: all state clears immediately; a pending kill pulse is dropped.

Test Plan:
- Reset; dispatch 4 branches (is_br=4'b1111) -> tags 0,1,2,3; brmasks 0x00, 0x01, 0x03, 0x07; o_free_count=4 next cycle.
- Live {0,1,2,3}; br_upd tag1 correct -> live=0x0D, no kill; next group is_br=4'b0001 -> tag1 reused, brmask 0x0D.
- Live 0..3 allocated in order; mispredict tag1 -> next cycle o_kill_valid=1, o_kill_mask=0x0E; live=0x01; o_free_count=7.
- Live 0..5; group with is_br=4'b0111 -> o_disp_ready=0, no state change; with tag0 freed the same cycle, the group is still rejected; next cycle accepted with tags 0,6,7.
- Flush with live=0xFF plus a same-cycle br_upd mispredict on tag 3 -> o_kill_mask=0xFF, live=0, single pulse, o_disp_ready=0 in the flush cycle.
- Assert i_reset one cycle after a mispredict -> o_kill_valid=0 immediately, live=0, o_free_count=8.
